uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Shares one UART transmit line among `NUM_REQ` byte sources and sequences each frame: start bit, data bits, optional parity bit, stop bits. Arbitration is round-robin. Bit timing comes from an oversample tick counter. The block sits between the DUT-side or BFM-side byte producers and the serial `tx` pin. Frame configuration (baud divisor, oversampling, data width, stop bits, parity) is supplied on static config ports and captured per frame.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 8, width of each requester data lane

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester byte available
- `req_data`  in  NUM_REQ*DATA_WIDTH  lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  NUM_REQ  one-hot acceptance pulse
- `cfg_clks_per_tick`  in  16  clk cycles per oversample tick; 0 is treated as 1
- `cfg_oversample_x13`  in  1  0 = x16, 1 = x13 ticks per bit
- `cfg_data_bits`  in  4  5..8; below 5 clamps to 5, above 8 clamps to 8
- `cfg_two_stop`  in  1  0 = one stop bit, 1 = two stop bits
- `cfg_parity_odd`  in  1  parity sense (see Configuration)
- `tx`  out  1  serial output, idle high
- `busy`  out  1  frame in progress
- `grant_id`  out  3  index of the requester currently or last served
- `frame_done`  out  1  one-cycle pulse at end of frame

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If any `req_valid` is set, grant the first set requester searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Pulse `req_ready[g]` for that cycle only.
  - Latch `req_data[g]`, `grant_id`, and all `cfg_*` inputs. Go to START.
- Config inputs are ignored mid-frame. Only the values latched at grant apply.
- Bit period B = max(cfg_clks_per_tick,1) × (16 or 13) clk cycles. A divider counter and a tick counter both reload at every bit boundary.
- START drives `tx` = 0 for one bit.
- DATA sends the clamped `cfg_data_bits` count, LSB first. Bits of `req_data` above the data width are ignored.
- PARITY state exists only when the macro is defined.
- STOP drives `tx` = 1 for 1 or 2 bits.
- `frame_done` and the `last_grant` update occur in the final cycle of STOP. The next cycle is IDLE.
- `busy` = 1 in every state except IDLE.
- Frame length L = 1 + n_data + p + n_stop bits, where p is 0 or 1.
- Reset values: `tx` = 1, `busy` = 0, `req_ready` = 0, `frame_done` = 0, `grant_id` = 0, `last_grant` = NUM_REQ-1 (so requester 0 is favoured first), FSM = IDLE.
- Reset asserted mid-frame aborts the frame immediately. `tx` returns high asynchronously and no `frame_done` pulse is produced.

## Timing
- Acceptance at cycle T: `req_ready` is high in T only. `tx` falls at T+1.
- Bit k (k = 0 is the start bit) occupies cycles T+1+k·B through T+(k+1)·B.
- `frame_done` is high at T+L·B. IDLE begins at T+L·B+1.
- The earliest next acceptance is T+L·B+1, and `tx` stays high in that cycle. Minimum inter-frame idle is therefore exactly one clk cycle.
- `req_valid` deasserting while `busy` has no effect. Requesters must hold data until they see `req_ready`.
- `req_valid` arriving in the same cycle as `frame_done` is not granted until the following IDLE cycle.
- With a single requester continuously valid, it is served back to back.

## Configuration
- Macro: `UART_TX_SCHED_PARITY_EN`.
- Defined:
  - A PARITY bit follows DATA.
  - Its value is XOR of the sent data bits, XOR `cfg_parity_odd`. This gives even parity when 0 and odd parity when 1.
  - p = 1.
- Undefined:
  - The PARITY state is absent, `cfg_parity_odd` is unused, and p = 0.

## Test plan
- Single frame: req0 sends 0xA5 with clks_per_tick = 1, x16, 8 data bits, one stop, no parity. Expect B = 16. Expect `tx` low for T+1..T+16, then data bits 1,0,1,0,0,1,0,1, then stop. Expect `frame_done` at T+160 and `busy` low at T+161.
- Round robin: all four `req_valid` held high. Expect grant sequence 0,1,2,3,0. Each `req_ready` is a single-cycle pulse separated by L·B+1 cycles.
- Parity on: 5 data bits, odd parity, data 0x1F. Expect serial 0,1,1,1,1,1,0,1 (parity 0). Expect `frame_done` at T+8·16.
- Timing variants: x13, clks_per_tick = 2, 8 data bits, two stop, no parity. Expect B = 26, L = 11, and `frame_done` at T+286.
- Config change mid-frame: `cfg_data_bits` changes from 8 to 5 during DATA. The current frame still sends 8 bits. The next frame sends 5.
- Reset mid-frame: assert `reset_n` during DATA bit 3. Expect `tx` = 1 and `busy` = 0 immediately. After release, with req1 and req0 both valid, req0 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Byte-request bundle between NUM_REQ producers and the UART transmit scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART frame scheduler: shares one tx line among NUM_REQ byte sources.
// Optional parity bit enabled by defining UART_TX_SCHED_PARITY_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_tx_scheduler_if.slave req_if,
    input  logic [15:0]        cfg_clks_per_tick,
    input  logic               cfg_oversample_x13,
    input  logic [3:0]         cfg_data_bits,
    input  logic               cfg_two_stop,
    input  logic               cfg_parity_odd,
    output logic               tx,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_SCHED_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state, w_next_state;
    logic [15:0]           r_clks_per_tick, r_div_cnt, w_clks_per_tick;
    logic [3:0]            r_tick_cnt;
    logic                  r_x13, r_two_stop;
    logic [2:0]            r_bits_m1, r_bit_cnt, w_bits_m1;
    logic [DATA_WIDTH-1:0] r_shift, w_lane;
    logic [2:0]            r_grant_id, r_last_grant, w_pick;
    logic                  w_any, w_tick_end, w_bit_end, w_last_data, w_last_stop;
    int                    w_best, w_dist;
`ifdef UART_TX_SCHED_PARITY_EN
    logic                  r_parity;
`else
    logic                  w_unused_parity;
    assign w_unused_parity = cfg_parity_odd;
`endif

    // Rotating priority: the requester just after last_grant has distance 0.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_lane = '0;
        w_best = NUM_REQ;
        w_dist = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
            if (req_if.req_valid[i] && (w_dist < w_best)) begin
                w_any  = 1'b1;
                w_best = w_dist;
                w_pick = 3'(i);
                w_lane = req_if.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        req_if.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_if.req_ready[i] = reset_n && (r_state == S_IDLE) && w_any && (w_pick == 3'(i));
    end

    assign w_clks_per_tick = (cfg_clks_per_tick == 16'd0) ? 16'd1 : cfg_clks_per_tick;

    always_comb begin
        if (cfg_data_bits < 4'd5)      w_bits_m1 = 3'd4;
        else if (cfg_data_bits > 4'd8) w_bits_m1 = 3'd7;
        else                           w_bits_m1 = 3'(cfg_data_bits - 4'd1);
    end

    assign w_tick_end  = (r_div_cnt == r_clks_per_tick - 16'd1);
    assign w_bit_end   = w_tick_end && (r_tick_cnt == (r_x13 ? 4'd12 : 4'd15));
    assign w_last_data = (r_bit_cnt == r_bits_m1);
    assign w_last_stop = (r_bit_cnt[0] == r_two_stop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_next_state = r_state;
        frame_done   = 1'b0;
        unique case (r_state)
            S_IDLE:   if (w_any) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = S_DATA;
`ifdef UART_TX_SCHED_PARITY_EN
            S_DATA:   if (w_bit_end && w_last_data) w_next_state = S_PARITY;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
`else
            S_DATA:   if (w_bit_end && w_last_data) w_next_state = S_STOP;
`endif
            S_STOP: begin
                if (w_bit_end && w_last_stop) begin
                    w_next_state = S_IDLE;
                    frame_done   = 1'b1;
                end
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // NOTE: async reset clears the state register, so tx (decoded from it) goes high immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clks_per_tick <= 16'd1;
            r_div_cnt       <= '0;
            r_tick_cnt      <= '0;
            r_x13           <= 1'b0;
            r_two_stop      <= 1'b0;
            r_bits_m1       <= 3'd7;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_grant_id      <= '0;
            r_last_grant    <= 3'(NUM_REQ - 1);
`ifdef UART_TX_SCHED_PARITY_EN
            r_parity        <= 1'b0;
`endif
        end else begin
            if (r_state == S_IDLE) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                if (w_any) begin
                    r_clks_per_tick <= w_clks_per_tick;
                    r_x13           <= cfg_oversample_x13;
                    r_two_stop      <= cfg_two_stop;
                    r_bits_m1       <= w_bits_m1;
                    r_shift         <= w_lane;
                    r_grant_id      <= w_pick;
`ifdef UART_TX_SCHED_PARITY_EN
                    r_parity        <= cfg_parity_odd;
`endif
                end
            end else if (w_bit_end) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= '0;
                if (r_state == S_DATA) begin
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= w_last_data ? 3'd0 : r_bit_cnt + 3'd1;
`ifdef UART_TX_SCHED_PARITY_EN
                    r_parity  <= r_parity ^ r_shift[0];
`endif
                end else if (r_state == S_STOP) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else if (w_tick_end) begin
                r_div_cnt  <= '0;
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end
            if (frame_done) r_last_grant <= r_grant_id;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = r_shift[0];
`ifdef UART_TX_SCHED_PARITY_EN
            S_PARITY: tx = r_parity;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant_id;

endmodule
